wb_select_unit: RTL and testbench
=================================

# wb_select_unit

Registered write-back stage for the NPC core, generalising the opcode-to-write-source decode into a handshaked, multi-cycle unit. It accepts one retiring instruction per handshake and selects its write-back value: PC+4, ALU result, immediate, or load data. For loads it waits for the memory response, then lane-selects and sign- or zero-extends the data. It drives the register-file write port and a one-cycle commit pulse.

## Interface
- XLEN, 32, datapath width (32 only for load extension; other widths affect PC/ALU/IMM paths)
- REG_AW, 5, register address width

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  unit can accept this cycle
- in_opcode  in  7  instruction opcode
- in_funct3  in  3  load size/sign
- in_rd  in  REG_AW  destination register
- in_pc  in  XLEN  instruction PC
- in_alu  in  XLEN  ALU result
- in_imm  in  XLEN  sign-extended U-immediate (already shifted for lui)
- in_addr_lo  in  2  load address bits [1:0]
- mem_rvalid  in  1  load data valid (single-cycle pulse)
- mem_rdata  in  XLEN  aligned load word
- rf_we  out  1  register write enable
- rf_waddr  out  REG_AW  write address
- rf_wdata  out  XLEN  write data
- commit  out  1  one-cycle pulse per retired instruction
- busy  out  1  load outstanding (state WAIT_MEM)
- wb_err  out  1  misaligned-load pulse (only with WB_MISALIGN_CHECK_EN, else tied 0)

## Operation
- Source decode by opcode:
  - 0010111 auipc, 0010011 OP-IMM, 0110011 OP -> ALU
  - 0110111 lui -> IMM
  - 1101111 jal, 1100111 jalr -> PC+4
  - 0000011 load -> MEM
  - all other opcodes -> NONE: no write, commit still pulses
- PC+4 is computed modulo 2^XLEN.
- rd==0: rf_we held 0; commit still pulses.
- FSM states are IDLE, WAIT_MEM and WRITE.
  - IDLE, in_valid: if the opcode is a load, go to WAIT_MEM; otherwise latch the result and go to WRITE.
  - WAIT_MEM, mem_rvalid: extend the data, latch it, and go to WRITE.
  - WRITE: assert rf_we/commit for one cycle. With a new in_valid, accept it in the same cycle; otherwise return to IDLE.
- in_ready = (state==IDLE) || (state==WRITE).
- Load extension:
  - funct3 000 lb: sign-extend byte lane in_addr_lo.
  - 100 lbu: zero-extend byte lane in_addr_lo.
  - 001 lh: sign-extend half lane in_addr_lo[1].
  - 101 lhu: zero-extend half lane in_addr_lo[1].
  - 010 lw: full word.
  - Other funct3 values: no write, commit pulses.
- mem_rvalid outside WAIT_MEM is ignored.

## Timing
- Reset values: state IDLE; rf_we, commit, busy, wb_err all 0; rf_waddr and rf_wdata 0; in_ready 1 from the first cycle after reset.
- Non-load accepted at edge N: rf_we/commit high in cycle N+1. Sustained throughput is 1 per cycle.
- Load accepted at edge N, mem_rvalid sampled at edge M>N: write in cycle M+1. mem_rvalid in cycle N itself is ignored.
- rf_waddr/rf_wdata are valid only while rf_we=1. They hold their last values otherwise.
- Reset asserted mid-load: return to IDLE next edge with no write. A late mem_rvalid is then ignored.

## Configuration
- WB_MISALIGN_CHECK_EN defined: lh/lhu with in_addr_lo[0]=1, or lw with in_addr_lo!=0, still waits for mem_rvalid. It then suppresses rf_we and pulses wb_err together with commit.
- Undefined: no check; the lane select uses the address bits listed above and ignores misalignment. wb_err is constant 0.

## Structure
- Package wb_pkg holds:
  - opcode localparams
  - funct3 load constants
  - wb_src_e {SRC_MEM=2'b00, SRC_PC4=2'b01, SRC_ALU=2'b10, SRC_IMM=2'b11}
  - separate no-write flag
  - wb_state_e {IDLE, WAIT_MEM, WRITE}
- Sub-module load_extend (combinational): inputs rdata, funct3, addr_lo; outputs data, illegal, misaligned.

## Test plan
- addi rd=5, alu=0x1234 -> next cycle rf_we=1, waddr=5, wdata=0x1234, commit=1.
- jal rd=1, pc=0xFFFFFFFC -> wdata=0x00000000; back-to-back lui rd=2, imm=0x80000000 on the following cycle -> wdata=0x80000000. Two consecutive commits.
- lb addr_lo=3, funct3=000, mem_rdata=0x80FF_0000 after 4 idle cycles:
  - busy=1 and in_ready=0 while waiting
  - then wdata=0xFFFFFF80
- lhu addr_lo=2, mem_rdata=0xBEEF1234 -> wdata=0x0000BEEF.
- lw addr_lo=1 with macro defined -> rf_we=0, wb_err=1, commit=1. Without macro -> wdata=mem_rdata.
- Load accepted, rst_n low before mem_rvalid; mem_rvalid after reset -> no rf_we, no commit, state IDLE.

Source files
------------

// File: rtl/wb_select_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared definitions for the write-back select unit: RISC-V
//            opcodes, load funct3 encodings, write-back source and FSM state
//            enums, and the opcode-to-source decode helper.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        SRC_MEM = 2'b00,
        SRC_PC4 = 2'b01,
        SRC_ALU = 2'b10,
        SRC_IMM = 2'b11
    } wb_src_e;

    // The no-write flag is kept apart from the source so that the four
    // sources fully occupy the 2-bit encoding.
    typedef struct packed {
        wb_src_e src;
        logic    nowrite;
    } wb_dec_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_MEM = 2'b01,
        WRITE    = 2'b10
    } wb_state_e;

    function automatic wb_dec_t decode_src(input logic [6:0] opc);
        wb_dec_t d;
        d.src     = SRC_ALU;
        d.nowrite = 1'b0;
        case (opc)
            OPC_AUIPC, OPC_OPIMM, OPC_OP: d.src = SRC_ALU;
            OPC_LUI:                      d.src = SRC_IMM;
            OPC_JAL, OPC_JALR:            d.src = SRC_PC4;
            OPC_LOAD:                     d.src = SRC_MEM;
            // Unknown opcodes must never be mistaken for a load, so the
            // source stays non-MEM and only the no-write flag is raised.
            default:                      d.nowrite = 1'b1;
        endcase
        return d;
    endfunction

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_select_unit_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Purpose  : Combinational lane select and sign/zero extension of an aligned
//            load word.
// Ports    : i rdata    - aligned load word
//            i funct3   - load size/sign
//            i addr_lo  - load address bits [1:0]
//            o data     - extended result
//            o illegal  - funct3 is not a supported load
//            o misaligned - half/word access not naturally aligned
// Revision : 1.0 - initial release
// ============================================================================
module load_extend
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] data,
    output logic            illegal,
    output logic            misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[7:0];
        case (addr_lo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
    end

    // Half lane comes from addr_lo[1] only; addr_lo[0] is reported through
    // misaligned and otherwise ignored.
    assign w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data       = '0;
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU: data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH: begin
                data       = {{(XLEN-16){w_half[15]}}, w_half};
                misaligned = addr_lo[0];
            end
            F3_LHU: begin
                data       = {{(XLEN-16){1'b0}}, w_half};
                misaligned = addr_lo[0];
            end
            F3_LW: begin
                data       = rdata;
                misaligned = (addr_lo != 2'd0);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule : load_extend
`default_nettype wire

// File: rtl/wb_select_unit.sv
`default_nettype none
// ============================================================================
// Module   : wb_select_unit
// Purpose  : Registered, handshaked write-back stage. Accepts one retiring
//            instruction per handshake, selects PC+4 / ALU / IMM / load data,
//            waits for the memory response on loads, and drives the
//            register-file write port plus a one-cycle commit pulse.
// Ports    : clk, rst_n (sync, active-low)
//            in_*       - instruction offer (valid/ready handshake)
//            mem_rvalid, mem_rdata - load response
//            rf_we, rf_waddr, rf_wdata - register-file write port
//            commit     - one pulse per retired instruction
//            busy       - load outstanding
//            wb_err     - misaligned-load pulse
// Config   : WB_MISALIGN_CHECK_EN - when defined, misaligned lh/lhu/lw loads
//            suppress the write and pulse wb_err; otherwise wb_err is 0.
// Revision : 1.0 - initial release
// ============================================================================
module wb_select_unit
    import wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [1:0]        in_addr_lo,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              commit,
    output logic              busy,
    output logic              wb_err
);

    wb_state_e         r_state;
    logic [REG_AW-1:0] r_rd;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic              r_rf_we;
    logic [REG_AW-1:0] r_rf_waddr;
    logic [XLEN-1:0]   r_rf_wdata;
    logic              r_commit;
    logic              r_wb_err;

    wb_dec_t           w_dec;
    logic [XLEN-1:0]   w_result;
    logic [XLEN-1:0]   w_ld_data;
    logic              w_ld_illegal;
    logic              w_ld_misaligned;
    logic              w_ld_fault;

    assign w_dec = decode_src(in_opcode);

    always_comb begin
        w_result = in_alu;
        case (w_dec.src)
            SRC_PC4: w_result = in_pc + XLEN'(4);
            SRC_IMM: w_result = in_imm;
            default: w_result = in_alu;
        endcase
    end

    // Extension works from the fields latched at accept time, so the
    // upstream stage is free to move on while the load is outstanding.
    load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .rdata      (mem_rdata),
        .funct3     (r_funct3),
        .addr_lo    (r_addr_lo),
        .data       (w_ld_data),
        .illegal    (w_ld_illegal),
        .misaligned (w_ld_misaligned)
    );

`ifdef WB_MISALIGN_CHECK_EN
    assign w_ld_fault = w_ld_misaligned;
`else
    logic w_unused;
    assign w_ld_fault = 1'b0;
    assign w_unused   = w_ld_misaligned;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rd       <= '0;
            r_funct3   <= '0;
            r_addr_lo  <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_commit   <= 1'b0;
            r_wb_err   <= 1'b0;
        end else begin
            r_rf_we  <= 1'b0;
            r_commit <= 1'b0;
            r_wb_err <= 1'b0;
            case (r_state)
                // WRITE accepts a new instruction in the same cycle it
                // retires the previous one, giving one retire per cycle.
                IDLE, WRITE: begin
                    if (in_valid) begin
                        if (w_dec.src == SRC_MEM) begin
                            r_rd      <= in_rd;
                            r_funct3  <= in_funct3;
                            r_addr_lo <= in_addr_lo;
                            r_state   <= WAIT_MEM;
                        end else begin
                            r_commit <= 1'b1;
                            r_state  <= WRITE;
                            // Write port fields only move on a real write.
                            if (!w_dec.nowrite && (in_rd != '0)) begin
                                r_rf_we    <= 1'b1;
                                r_rf_waddr <= in_rd;
                                r_rf_wdata <= w_result;
                            end
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        r_commit <= 1'b1;
                        r_wb_err <= w_ld_fault;
                        r_state  <= WRITE;
                        if (!w_ld_illegal && !w_ld_fault && (r_rd != '0)) begin
                            r_rf_we    <= 1'b1;
                            r_rf_waddr <= r_rd;
                            r_rf_wdata <= w_ld_data;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready = (r_state == IDLE) || (r_state == WRITE);
    assign busy     = (r_state == WAIT_MEM);
    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;
    assign commit   = r_commit;
    assign wb_err   = r_wb_err;

endmodule : wb_select_unit
`default_nettype wire

// File: tb/tb_wb_select_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_select_unit
// Purpose  : Self-checking bench for wb_select_unit: a table of directed
//            single-instruction vectors plus hand-written multi-cycle
//            sequences (back-to-back retire, long load wait, reset mid-load).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_select_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic [31:0] in_pc;
    logic [31:0] in_alu;
    logic [31:0] in_imm;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        commit;
    logic        busy;
    logic        wb_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_select_unit #(.XLEN(32), .REG_AW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_funct3  (in_funct3),
        .in_rd      (in_rd),
        .in_pc      (in_pc),
        .in_alu     (in_alu),
        .in_imm     (in_imm),
        .in_addr_lo (in_addr_lo),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .commit     (commit),
        .busy       (busy),
        .wb_err     (wb_err)
    );

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] imm;
        logic [1:0]  alo;
        logic [31:0] rdata;
        logic        exp_we;
        logic [31:0] exp_wd;
        logic        exp_err;
    } vec_t;

    localparam int NV = 17;
    vec_t vt[NV];

    function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3,
                                input logic [4:0] rd, input logic [31:0] pc,
                                input logic [31:0] alu, input logic [31:0] imm,
                                input logic [1:0] alo, input logic [31:0] rdata,
                                input logic exp_we, input logic [31:0] exp_wd,
                                input logic exp_err);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.rd = rd; v.pc = pc; v.alu = alu; v.imm = imm;
        v.alo = alo; v.rdata = rdata; v.exp_we = exp_we; v.exp_wd = exp_wd;
        v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic offer(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] imm, input logic [1:0] alo);
        in_valid = 1'b1; in_opcode = opc; in_funct3 = f3; in_rd = rd;
        in_pc = pc; in_alu = alu; in_imm = imm; in_addr_lo = alo;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_funct3 = '0; in_rd = '0;
        in_pc = '0; in_alu = '0; in_imm = '0; in_addr_lo = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;

        vt[0]  = mk(7'b0010011, 3'd0, 5'd5,  32'h0, 32'h0000_1234, 32'h0, 2'd0, 32'h0, 1'b1, 32'h0000_1234, 1'b0);
        vt[1]  = mk(7'b0010111, 3'd0, 5'd6,  32'h0, 32'hDEAD_BEEF, 32'h0, 2'd0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        vt[2]  = mk(7'b0110011, 3'd0, 5'd31, 32'h0, 32'h0000_0001, 32'h0, 2'd0, 32'h0, 1'b1, 32'h0000_0001, 1'b0);
        vt[3]  = mk(7'b0110111, 3'd0, 5'd2,  32'h0, 32'h5555_5555, 32'h8000_0000, 2'd0, 32'h0, 1'b1, 32'h8000_0000, 1'b0);
        vt[4]  = mk(7'b1101111, 3'd0, 5'd1,  32'hFFFF_FFFC, 32'h0, 32'h0, 2'd0, 32'h0, 1'b1, 32'h0000_0000, 1'b0);
        vt[5]  = mk(7'b1100111, 3'd0, 5'd3,  32'h0000_0100, 32'h0, 32'h0, 2'd0, 32'h0, 1'b1, 32'h0000_0104, 1'b0);
        vt[6]  = mk(7'b0010011, 3'd0, 5'd0,  32'h0, 32'hFFFF_FFFF, 32'h0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        vt[7]  = mk(7'b0100011, 3'd0, 5'd7,  32'h0, 32'h1111_1111, 32'h0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        vt[8]  = mk(7'b0000011, 3'b000, 5'd10, 32'h0, 32'h0, 32'h0, 2'd3, 32'h80FF_0000, 1'b1, 32'hFFFF_FF80, 1'b0);
        vt[9]  = mk(7'b0000011, 3'b100, 5'd11, 32'h0, 32'h0, 32'h0, 2'd1, 32'h1234_F1AB, 1'b1, 32'h0000_00F1, 1'b0);
        vt[10] = mk(7'b0000011, 3'b000, 5'd12, 32'h0, 32'h0, 32'h0, 2'd0, 32'hAAAA_AA7F, 1'b1, 32'h0000_007F, 1'b0);
        vt[11] = mk(7'b0000011, 3'b001, 5'd13, 32'h0, 32'h0, 32'h0, 2'd2, 32'h8001_0000, 1'b1, 32'hFFFF_8001, 1'b0);
        vt[12] = mk(7'b0000011, 3'b101, 5'd14, 32'h0, 32'h0, 32'h0, 2'd2, 32'hBEEF_1234, 1'b1, 32'h0000_BEEF, 1'b0);
        vt[13] = mk(7'b0000011, 3'b010, 5'd15, 32'h0, 32'h0, 32'h0, 2'd0, 32'hCAFE_BABE, 1'b1, 32'hCAFE_BABE, 1'b0);
        vt[14] = mk(7'b0000011, 3'b011, 5'd16, 32'h0, 32'h0, 32'h0, 2'd0, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
`ifdef WB_MISALIGN_CHECK_EN
        vt[15] = mk(7'b0000011, 3'b010, 5'd17, 32'h0, 32'h0, 32'h0, 2'd1, 32'h1234_5678, 1'b0, 32'h0, 1'b1);
        vt[16] = mk(7'b0000011, 3'b001, 5'd18, 32'h0, 32'h0, 32'h0, 2'd1, 32'h0000_8000, 1'b0, 32'h0, 1'b1);
`else
        vt[15] = mk(7'b0000011, 3'b010, 5'd17, 32'h0, 32'h0, 32'h0, 2'd1, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0);
        vt[16] = mk(7'b0000011, 3'b001, 5'd18, 32'h0, 32'h0, 32'h0, 2'd1, 32'h0000_8000, 1'b1, 32'hFFFF_8000, 1'b0);
`endif

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst rf_we",    {31'd0, rf_we},    32'd0);
        chk("rst commit",   {31'd0, commit},   32'd0);
        chk("rst busy",     {31'd0, busy},     32'd0);
        chk("rst wb_err",   {31'd0, wb_err},   32'd0);
        chk("rst rf_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("rst rf_wdata", rf_wdata,          32'd0);

        // Table of single instructions; each is offered in the cycle its
        // predecessor retires.
        for (int i = 0; i < NV; i++) begin
            offer(vt[i].opc, vt[i].f3, vt[i].rd, vt[i].pc, vt[i].alu, vt[i].imm, vt[i].alo);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            if (vt[i].opc == 7'b0000011) begin
                chk($sformatf("v%0d busy", i), {31'd0, busy}, 32'd1);
                chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd0);
                mem_rdata  = vt[i].rdata;
                mem_rvalid = 1'b1;
                @(posedge clk);
                @(negedge clk);
                mem_rvalid = 1'b0;
            end
            chk($sformatf("v%0d rf_we", i),  {31'd0, rf_we},  {31'd0, vt[i].exp_we});
            chk($sformatf("v%0d commit", i), {31'd0, commit}, 32'd1);
            chk($sformatf("v%0d wb_err", i), {31'd0, wb_err}, {31'd0, vt[i].exp_err});
            if (vt[i].exp_we) begin
                chk($sformatf("v%0d waddr", i), {27'd0, rf_waddr}, {27'd0, vt[i].rd});
                chk($sformatf("v%0d wdata", i), rf_wdata, vt[i].exp_wd);
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("idle commit", {31'd0, commit}, 32'd0);
        chk("idle rf_we",  {31'd0, rf_we},  32'd0);

        // Back-to-back jal then lui
        offer(7'b1101111, 3'd0, 5'd1, 32'hFFFF_FFFC, 32'h0, 32'h0, 2'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b jal we",    {31'd0, rf_we},    32'd1);
        chk("b2b jal wdata", rf_wdata,          32'h0);
        chk("b2b jal ready", {31'd0, in_ready}, 32'd1);
        offer(7'b0110111, 3'd0, 5'd2, 32'h0, 32'h0, 32'h8000_0000, 2'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b lui commit", {31'd0, commit},   32'd1);
        chk("b2b lui waddr",  {27'd0, rf_waddr}, 32'd2);
        chk("b2b lui wdata",  rf_wdata,          32'h8000_0000);
        @(posedge clk);
        @(negedge clk);

        // lb with response in the accept cycle (ignored) and a 4-cycle wait
        offer(7'b0000011, 3'b000, 5'd9, 32'h0, 32'h0, 32'h0, 2'd3);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("lbw%0d busy", k),  {31'd0, busy},     32'd1);
            chk($sformatf("lbw%0d ready", k), {31'd0, in_ready}, 32'd0);
            chk($sformatf("lbw%0d commit", k), {31'd0, commit},  32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80FF_0000;
        @(posedge clk);
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("lbw rf_we", {31'd0, rf_we},    32'd1);
        chk("lbw waddr", {27'd0, rf_waddr}, 32'd9);
        chk("lbw wdata", rf_wdata,          32'hFFFF_FF80);
        @(posedge clk);
        @(negedge clk);
        chk("lbw after commit", {31'd0, commit}, 32'd0);

        // Reset while a load is outstanding; the late response is dropped
        offer(7'b0000011, 3'b010, 5'd20, 32'h0, 32'h0, 32'h0, 2'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rml busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rml busy after rst",  {31'd0, busy},     32'd0);
        chk("rml ready after rst", {31'd0, in_ready}, 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_0001;
        @(posedge clk);
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rml rf_we",  {31'd0, rf_we},  32'd0);
        chk("rml commit", {31'd0, commit}, 32'd0);
        chk("rml busy",   {31'd0, busy},   32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rml commit2", {31'd0, commit}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_wb_select_unit
`default_nettype wire
